// File: rtl/alu_cmd_sched.sv
// Two-port round-robin command scheduler in front of a single registered ALU.
// One operation in flight at a time: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
module alu_cmd_sched #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0_VALID,
  input  logic [WIDTH-1:0]     REQ0_A,
  input  logic [WIDTH-1:0]     REQ0_B,
  input  logic [3:0]           REQ0_FUN,
  output logic                 REQ0_READY,
  input  logic                 REQ1_VALID,
  input  logic [WIDTH-1:0]     REQ1_A,
  input  logic [WIDTH-1:0]     REQ1_B,
  input  logic [3:0]           REQ1_FUN,
  output logic                 REQ1_READY,
  output logic [WIDTH-1:0]     ALU_A,
  output logic [WIDTH-1:0]     ALU_B,
  output logic [3:0]           ALU_FUN,
  output logic                 ALU_EN,
  input  logic [2*WIDTH-1:0]   ALU_OUT,
  output logic                 ALU_CLK_EN,
  output logic                 RSP_VALID,
  output logic [2*WIDTH-1:0]   RSP_DATA,
  output logic                 RSP_ID,
  input  logic                 RSP_READY,
  output logic                 BUSY,
  output logic [1:0]           DBG_STATE
);

  // Handshakes: a request transfers on a rising edge where REQn_VALID and
  // REQn_READY are both high; a response transfers where RSP_VALID and
  // RSP_READY are both high. A producer holds its payload until it transfers.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_last_id;
  logic [WIDTH-1:0]     r_alu_a;
  logic [WIDTH-1:0]     r_alu_b;
  logic [3:0]           r_alu_fun;
  logic [2*WIDTH-1:0]   r_rsp_data;
  logic                 r_rsp_id;

  logic                 w_grant0;
  logic                 w_grant1;
  logic                 w_accept;
  logic                 w_accept_id;

  // Grant only while idle and out of reset; on a tie the port that did not
  // win last time gets the slot.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (RST && (r_state == ST_IDLE)) begin
      if (REQ0_VALID && REQ1_VALID) begin
        w_grant0 = r_last_id;
        w_grant1 = ~r_last_id;
      end else begin
        w_grant0 = REQ0_VALID;
        w_grant1 = REQ1_VALID;
      end
    end
  end

  assign w_accept    = w_grant0 | w_grant1;
  assign w_accept_id = w_grant1;
  assign REQ0_READY  = w_grant0;
  assign REQ1_READY  = w_grant1;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next_state = ST_ISSUE;
      ST_ISSUE:   w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_RESP;
      ST_RESP:    if (RSP_READY) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ALU_EN     = 1'b0;
    ALU_CLK_EN = 1'b0;
    RSP_VALID  = 1'b0;
    BUSY       = 1'b1;
    case (r_state)
      ST_IDLE:    BUSY = 1'b0;
      ST_ISSUE: begin
        ALU_EN     = 1'b1;
        ALU_CLK_EN = 1'b1;
      end
      ST_CAPTURE: ALU_CLK_EN = 1'b1;
      ST_RESP:    RSP_VALID  = 1'b1;
      default:    BUSY = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand registers only move on acceptance, so the ALU inputs stay quiet
  // between operations.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_fun  <= '0;
      r_rsp_id   <= 1'b0;
      r_last_id  <= 1'b1;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a   <= w_accept_id ? REQ1_A   : REQ0_A;
        r_alu_b   <= w_accept_id ? REQ1_B   : REQ0_B;
        r_alu_fun <= w_accept_id ? REQ1_FUN : REQ0_FUN;
        r_rsp_id  <= w_accept_id;
        r_last_id <= w_accept_id;
      end
      if (r_state == ST_CAPTURE) begin
        r_rsp_data <= ALU_OUT;
      end
    end
  end

  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_FUN   = r_alu_fun;
  assign RSP_DATA  = r_rsp_data;
  assign RSP_ID    = r_rsp_id;
  assign DBG_STATE = r_state;

endmodule
